scan_crypto_seq: RTL
====================

Name: scan_crypto_seq

Overview:
- Sequencer for the 128-bit serial-in / AES-encrypt / serial-out scan encryption datapath in the IEEE 1838 3D-IC die wrapper.
- Counts scan bits into the SIPO, issues the AES start once the key is valid, and waits for completion with a timeout.
- Then loads the PISO and meters shift-out under a ready handshake.
- Sits between the die-level scan control (shift_en / out_ready) and the SIPO/AES/PISO datapath.

Parameters:
- BLOCK_W, 128, bits per block in and out
- CNT_W, 8, width of the bit counters (must satisfy 2^CNT_W > BLOCK_W)
- TIMEOUT, 64, maximum cycles in WAIT before error
- BLKCNT_W, 16, width of the completed-block counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- shift_en  in  1  scan bit present on the datapath serial input this cycle
- out_ready  in  1  downstream accepts one serial output bit this cycle
- key_valid  in  1  initial_key is stable and usable
- aes_done  in  1  AES core finished (level or pulse)
- abort  in  1  synchronous abort of the current block
- ready_in  out  1  controller accepts input bits
- sipo_shift  out  1  SIPO shift enable
- aes_start  out  1  one-cycle AES start pulse
- piso_load  out  1  one-cycle PISO parallel load
- piso_shift  out  1  PISO shift enable
- out_valid  out  1  serial_out bit valid
- busy  out  1  block in progress
- err_timeout  out  1  sticky AES timeout flag
- blk_cnt  out  BLKCNT_W  completed-block count

Behaviour:
- Reset: state IDLE. All counters 0. All outputs 0, except ready_in=1.
- States: IDLE, LOAD, START, WAIT, XFER, UNLOAD, ERR.
- Outputs are Moore decodes of state plus registers, except sipo_shift and piso_shift, which are combinational.
  - sipo_shift = shift_en & ready_in.
  - ready_in = 1 only in IDLE and LOAD.
  - busy = 1 in every state except IDLE.
- IDLE/LOAD:
  - Each cycle with sipo_shift=1 increments bit_cnt.
  - First accepted bit moves IDLE->LOAD.
  - The accepted bit with bit_cnt==BLOCK_W-1 clears bit_cnt and moves to START.
  - Gaps in shift_en hold the count.
- START:
  - If key_valid=1: aes_start=1 for exactly this one cycle, then move to WAIT.
  - If key_valid=0: stay in START with aes_start=0.
- WAIT:
  - Timer starts at 0 on entry and increments each cycle.
  - aes_done=1 moves to XFER.
  - Timer reaching TIMEOUT-1 without aes_done moves to ERR and sets err_timeout.
  - If aes_done arrives in the same cycle the timer reaches TIMEOUT-1, aes_done wins.
  - aes_done is ignored in every state other than WAIT.
- XFER: piso_load=1 for one cycle, then move to UNLOAD.
- UNLOAD:
  - out_valid=1.
  - piso_shift = out_ready; each cycle with piso_shift=1 increments out_cnt.
  - The shift with out_cnt==BLOCK_W-1 clears out_cnt, increments blk_cnt (wraps modulo 2^BLKCNT_W) and returns to IDLE.
  - The next block may start loading on the following cycle.
- ERR:
  - All strobes 0; busy=1.
  - Only abort or reset leaves ERR.
- abort (any state):
  - Next state IDLE; bit_cnt, out_cnt and timer cleared; err_timeout cleared.
  - blk_cnt is kept.
  - abort has priority over every other transition in the same cycle.
  - sipo_shift and piso_shift are forced 0 while abort=1.
- Reset mid-operation: immediate return to the reset state, including blk_cnt=0.

Optional Feature:
- Macro: SCAN_CRYPTO_BYPASS_EN.
- With the macro defined:
  - Adds input port bypass (1 bit), sampled when the last input bit is accepted.
  - If bypass=1, LOAD goes directly to XFER: no aes_start, no key_valid wait.
  - Adds output crypt_sel, driven with the sampled value inverted so the datapath mux selects raw SIPO data.
- Without the macro: neither port exists, and every block passes through START/WAIT.

Test Plan:
- Nominal block:
  - Stimulus: key_valid=1; shift 128 bits of 0xAA..AA with continuous shift_en; aes_done 12 cycles after aes_start; out_ready=1.
  - Required: aes_start one cycle after the 128th bit; piso_load one cycle after aes_done; exactly 128 out_valid&piso_shift cycles; blk_cnt=1; ready_in returns to 1.
- Key gating:
  - Stimulus: key_valid=0 at end of load, raised 20 cycles later.
  - Required: START held, aes_start asserted exactly once, in the cycle key_valid=1.
- Timeout:
  - Stimulus: aes_done never asserted.
  - Required: err_timeout=1 after 64 WAIT cycles; no piso_load; abort returns to IDLE with err_timeout=0 and blk_cnt unchanged.
- Backpressure/gaps:
  - Stimulus: shift_en toggled every other cycle; out_ready at a 1-in-3 duty.
  - Required: still exactly 128 sipo_shift and 128 piso_shift pulses.
- Abort/reset:
  - Stimulus: abort at bit 50 of LOAD, then a full block.
  - Required: the second block needs the full 128 bits.
  - Stimulus: reset_n low mid-UNLOAD.
  - Required: all outputs at reset values; blk_cnt=0.
- Back-to-back and bypass:
  - Stimulus: 3 consecutive blocks.
  - Required: blk_cnt=3.
  - Stimulus (with SCAN_CRYPTO_BYPASS_EN): bypass=1.
  - Required: piso_load one cycle after the 128th bit; aes_start never asserted.

Source files
------------

// File: rtl/scan_crypto_seq.sv
// Sequencer for the serial-in / AES / serial-out scan encryption datapath.
// Optional raw-data bypass is compiled in with SCAN_CRYPTO_BYPASS_EN.
module scan_crypto_seq #(
    parameter int unsigned BLOCK_W  = 128,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned BLKCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                shift_en,
    input  logic                out_ready,
    input  logic                key_valid,
    input  logic                aes_done,
    input  logic                abort,
`ifdef SCAN_CRYPTO_BYPASS_EN
    input  logic                bypass,
    output logic                crypt_sel,
`endif
    output logic                ready_in,
    output logic                sipo_shift,
    output logic                aes_start,
    output logic                piso_load,
    output logic                piso_shift,
    output logic                out_valid,
    output logic                busy,
    output logic                err_timeout,
    output logic [BLKCNT_W-1:0] blk_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] BitLast = CNT_W'(BLOCK_W - 1);
    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StWait, StXfer, StUnload, StErr
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                err_q, err_d;
    logic [BLKCNT_W-1:0] blk_q, blk_d;
    logic                ready_q, busy_q, load_q, ov_q;
`ifdef SCAN_CRYPTO_BYPASS_EN
    logic                csel_q, csel_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        out_cnt_d = out_cnt_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        blk_d     = blk_q;
`ifdef SCAN_CRYPTO_BYPASS_EN
        csel_d    = csel_q;
`endif
        sipo_shift = shift_en & ready_q & ~abort;
        piso_shift = out_ready & ov_q & ~abort;
        // The start pulse must coincide with the cycle key_valid is seen in START.
        aes_start  = (state_q == StStart) & key_valid & ~abort;

        if (abort) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            out_cnt_d = '0;
            tmr_d     = '0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StLoad: begin
                    if (sipo_shift) begin
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
                            state_d   = StStart;
`ifdef SCAN_CRYPTO_BYPASS_EN
                            csel_d = ~bypass;
                            if (bypass) state_d = StXfer;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            state_d   = StLoad;
                        end
                    end
                end
                StStart: begin
                    tmr_d = '0;
                    if (key_valid) state_d = StWait;
                end
                StWait: begin
                    if (aes_done) begin
                        state_d = StXfer;
                    end else if (tmr_q == TmrLast) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StXfer: state_d = StUnload;
                StUnload: begin
                    if (piso_shift) begin
                        if (out_cnt_q == BitLast) begin
                            out_cnt_d = '0;
                            blk_d     = blk_q + 1'b1;
                            state_d   = StIdle;
                        end else begin
                            out_cnt_d = out_cnt_q + 1'b1;
                        end
                    end
                end
                StErr: state_d = StErr;
                default: state_d = StIdle;
            endcase
        end
    end

    // Moore outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            out_cnt_q <= '0;
            tmr_q     <= '0;
            err_q     <= 1'b0;
            blk_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
            ov_q      <= 1'b0;
`ifdef SCAN_CRYPTO_BYPASS_EN
            csel_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            out_cnt_q <= out_cnt_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            blk_q     <= blk_d;
            ready_q   <= (state_d == StIdle) || (state_d == StLoad);
            busy_q    <= (state_d != StIdle);
            load_q    <= (state_d == StXfer);
            ov_q      <= (state_d == StUnload);
`ifdef SCAN_CRYPTO_BYPASS_EN
            csel_q    <= csel_d;
`endif
        end
    end

    assign ready_in    = ready_q;
    assign busy        = busy_q;
    assign piso_load   = load_q;
    assign out_valid   = ov_q;
    assign err_timeout = err_q;
    assign blk_cnt     = blk_q;
`ifdef SCAN_CRYPTO_BYPASS_EN
    assign crypt_sel   = csel_q;
`endif

endmodule
